// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: writeback-select encodings, MEM-stage FSM
// states and the default access timeout.
package mips_pkg;

   localparam int          DATA_W_DEFAULT  = 32;
   localparam int          TIMEOUT_DEFAULT = 16;

   localparam logic [1:0]  MTR_ALU = 2'b00;
   localparam logic [1:0]  MTR_MEM = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
interface mem_stage_if #(
   parameter int DATA_W = 32
);

   // dmem_req stays high, with address/data/we stable, until the cycle the
   // memory raises dmem_ready; dmem_rdata is meaningful only in that cycle.
   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ready;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on completion, drops RegWrite on a bubble,
// otherwise holds.
module mem_wb_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en_i,
   input  logic              bubble_i,
   input  logic [1:0]        MemtoReg_i,
   input  logic              RegWrite_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [4:0]        WriteRegister_i,
   output logic [1:0]        MemtoReg_o,
   output logic              RegWrite_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [4:0]        WriteRegister_o
);

   logic [1:0]        mtr_q;
   logic              rw_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] alu_q;
   logic [4:0]        wreg_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mtr_q   <= '0;
         rw_q    <= 1'b0;
         rdata_q <= '0;
         alu_q   <= '0;
         wreg_q  <= '0;
      end else if (load_en_i) begin
         mtr_q   <= MemtoReg_i;
         rw_q    <= RegWrite_i;
         rdata_q <= mem_rdata_i;
         alu_q   <= alu_result_i;
         wreg_q  <= WriteRegister_i;
      end else if (bubble_i) begin
         rw_q    <= 1'b0;
      end
   end

   assign MemtoReg_o      = mtr_q;
   assign RegWrite_o      = rw_q;
   assign mem_rdata_o     = rdata_q;
   assign alu_result_o    = alu_q;
   assign WriteRegister_o = wreg_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch/jump redirect, data-memory access with stall and timeout,
// misalignment trap and the MEM/WB register.
module mem_stage
   import mips_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        MemtoReg_i,
   input  logic              Jump_i,
   input  logic              Branch_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              RegWrite_i,
   input  logic [DATA_W-1:0] PC_beq_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] ReadData2_i,
   input  logic              zero_flag_i,
   input  logic [4:0]        WriteRegister_i,
   mem_stage_if.master       dmem,
   output logic              stall_o,
   output logic              pc_src_o,
   output logic [DATA_W-1:0] pc_target_o,
   output logic              jump_o,
   output logic [1:0]        MemtoReg_o,
   output logic              RegWrite_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [4:0]        WriteRegister_o,
   output logic              bus_err_o,
   output logic              align_err_o,
   output state_t            state_o
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_err_q, align_err_q;
   logic              mem_op, misaligned;
   logic              complete, stall, err_gate, rd_ok, set_bus, set_align;

   assign mem_op     = MemRead_i | MemWrite_i;
   assign misaligned = mem_op & (alu_result_i[1:0] != 2'b00);

   assign dmem.dmem_req   = mem_op & ~misaligned & ((state_q == IDLE) | (state_q == WAIT));
   assign dmem.dmem_we    = MemWrite_i;
   assign dmem.dmem_addr  = alu_result_i;
   assign dmem.dmem_wdata = ReadData2_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      complete  = 1'b0;
      stall     = 1'b0;
      err_gate  = 1'b0;
      rd_ok     = 1'b0;
      set_bus   = 1'b0;
      set_align = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!mem_op) begin
               complete = 1'b1;
            end else if (misaligned) begin
               complete  = 1'b1;
               err_gate  = 1'b1;
               set_align = 1'b1;
            end else if (dmem.dmem_ready) begin
               complete = 1'b1;
               rd_ok    = MemRead_i & ~MemWrite_i;
            end else begin
               stall   = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Ready in the timeout cycle still counts as a successful access.
            if (dmem.dmem_ready) begin
               complete = 1'b1;
               rd_ok    = MemRead_i & ~MemWrite_i;
               cnt_d    = '0;
               state_d  = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               complete = 1'b1;
               err_gate = 1'b1;
               set_bus  = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (set_bus)   bus_err_q   <= 1'b1;
         if (set_align) align_err_q <= 1'b1;
      end
   end

   mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
      .clk             (clk),
      .reset           (reset),
      .load_en_i       (complete),
      .bubble_i        (stall),
      .MemtoReg_i      (MemtoReg_i),
      .RegWrite_i      (RegWrite_i & ~err_gate),
      .mem_rdata_i     (rd_ok ? dmem.dmem_rdata : '0),
      .alu_result_i    (alu_result_i),
      .WriteRegister_i (WriteRegister_i),
      .MemtoReg_o      (MemtoReg_o),
      .RegWrite_o      (RegWrite_o),
      .mem_rdata_o     (mem_rdata_o),
      .alu_result_o    (alu_result_o),
      .WriteRegister_o (WriteRegister_o)
   );

   assign stall_o     = stall;
   assign pc_src_o    = Branch_i & zero_flag_i & ~stall;
   assign pc_target_o = PC_beq_i;
   assign jump_o      = Jump_i & ~stall;
   assign bus_err_o   = bus_err_q;
   assign align_err_o = align_err_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver issues EX/MEM vectors and checks the
// combinational side; a negedge monitor checks MEM/WB against a queue.
module tb_mem_stage;
   import mips_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int EXP_W   = 74;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  MemtoReg_i;
   logic        Jump_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, zero_flag_i;
   logic [31:0] PC_beq_i, alu_result_i, ReadData2_i;
   logic [4:0]  WriteRegister_i;
   logic        stall_o, pc_src_o, jump_o, RegWrite_o, bus_err_o, align_err_o;
   logic [31:0] pc_target_o, mem_rdata_o, alu_result_o;
   logic [1:0]  MemtoReg_o;
   logic [4:0]  WriteRegister_o;
   state_t      state_o;

   logic             tb_vld = 1'b0;
   logic             pending = 1'b0;
   logic [EXP_W-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   mem_stage_if #(.DATA_W(32)) dmem_bus ();

   mem_stage #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .MemtoReg_i(MemtoReg_i), .Jump_i(Jump_i),
      .Branch_i(Branch_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .RegWrite_i(RegWrite_i), .PC_beq_i(PC_beq_i), .alu_result_i(alu_result_i),
      .ReadData2_i(ReadData2_i), .zero_flag_i(zero_flag_i),
      .WriteRegister_i(WriteRegister_i), .dmem(dmem_bus.master),
      .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
      .jump_o(jump_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
      .mem_rdata_o(mem_rdata_o), .alu_result_o(alu_result_o),
      .WriteRegister_o(WriteRegister_o), .bus_err_o(bus_err_o),
      .align_err_o(align_err_o), .state_o(state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      MemtoReg_i = 2'b00; Jump_i = 1'b0; Branch_i = 1'b0; MemRead_i = 1'b0;
      MemWrite_i = 1'b0; RegWrite_i = 1'b0; zero_flag_i = 1'b0;
      PC_beq_i = '0; alu_result_i = '0; ReadData2_i = '0; WriteRegister_i = '0;
      dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = '0;
   endtask

   // driver: hold one EX/MEM vector until the stage stops stalling
   task automatic issue(input logic mr, input logic mw, input logic rw, input logic [1:0] mtr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wreg,
                        input logic br, input logic zr, input logic jmp, input logic [31:0] pcb,
                        input int wait_n, input logic [31:0] rd,
                        input int exp_stall, input int exp_req, input logic [EXP_W-1:0] exp_v);
      int  cyc;
      logic done, stall_e;
      MemRead_i = mr; MemWrite_i = mw; RegWrite_i = rw; MemtoReg_i = mtr;
      alu_result_i = addr; ReadData2_i = wdata; WriteRegister_i = wreg;
      Branch_i = br; zero_flag_i = zr; Jump_i = jmp; PC_beq_i = pcb;
      tb_vld = 1'b1;
      exp_q.push_back(exp_v);
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 64) begin
         dmem_bus.dmem_ready = (wait_n >= 0) && (cyc == wait_n);
         dmem_bus.dmem_rdata = dmem_bus.dmem_ready ? rd : 32'h1111_1111;
         @(negedge clk);
         stall_e = (cyc < exp_stall);
         chk("stall", 32'(stall_o), 32'(stall_e));
         chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(cyc < exp_req));
         if (cyc < exp_req) chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(mw));
         if (cyc == 0) begin
            chk("dmem_addr", dmem_bus.dmem_addr, addr);
            chk("dmem_wdata", dmem_bus.dmem_wdata, wdata);
            chk("pc_target", pc_target_o, pcb);
         end
         chk("pc_src", 32'(pc_src_o), 32'(br & zr & ~stall_e));
         chk("jump", 32'(jump_o), 32'(jmp & ~stall_e));
         if (cyc > 0) chk("bubble_regwrite", 32'(RegWrite_o), 32'd0);
         if (!stall_o) done = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL stall_bound: stall_o still 1 after %0d cycles, required 0", cyc);
      end
      tb_vld = 1'b0;
      drive_idle();
   endtask

   // scoreboard monitor: one cycle after a completion, MEM/WB must match
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (pending) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL mon_underflow: got completion, expected none");
         end else begin
            e = exp_q.pop_front();
            chk("mon_memtoreg", 32'(MemtoReg_o), 32'(e[73:72]));
            chk("mon_regwrite", 32'(RegWrite_o), 32'(e[71]));
            chk("mon_rdata", mem_rdata_o, e[70:39]);
            chk("mon_alu", alu_result_o, e[38:7]);
            chk("mon_wreg", 32'(WriteRegister_o), 32'(e[6:2]));
            chk("mon_bus_err", 32'(bus_err_o), 32'(e[1]));
            chk("mon_align_err", 32'(align_err_o), 32'(e[0]));
         end
      end
      pending <= tb_vld && !stall_o && !reset;
   end

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
      chk("rst_rdata", mem_rdata_o, 32'd0);
      chk("rst_alu", alu_result_o, 32'd0);
      chk("rst_errs", 32'({bus_err_o, align_err_o}), 32'd0);
      chk("rst_state", 32'(state_o), 32'(IDLE));
      @(posedge clk);
      #1;

      //     mr   mw   rw   mtr      addr          wdata          wreg  br   zr   jmp  pcb           wait rdata          st  req  expected {mtr,rw,rdata,alu,wreg,bus,align}
      issue(1'b1,1'b0,1'b1,MTR_MEM, 32'h10,       32'h0,         5'd8, 1'b0,1'b0,1'b0,32'h0,        0,  32'hDEADBEEF,  0,  1,
            {MTR_MEM,1'b1,32'hDEADBEEF,32'h10,5'd8,1'b0,1'b0});
      issue(1'b0,1'b1,1'b0,MTR_ALU, 32'h20,       32'h12345678,  5'd0, 1'b0,1'b0,1'b0,32'h0,        3,  32'hAAAA5555,  3,  4,
            {MTR_ALU,1'b0,32'h0,32'h20,5'd0,1'b0,1'b0});
      issue(1'b0,1'b0,1'b0,MTR_ALU, 32'h0,        32'h0,         5'd0, 1'b1,1'b1,1'b0,32'h400,      0,  32'h0,         0,  0,
            {MTR_ALU,1'b0,32'h0,32'h0,5'd0,1'b0,1'b0});
      issue(1'b0,1'b0,1'b0,MTR_ALU, 32'h5,        32'h0,         5'd0, 1'b1,1'b0,1'b0,32'h400,      0,  32'h0,         0,  0,
            {MTR_ALU,1'b0,32'h0,32'h5,5'd0,1'b0,1'b0});
      issue(1'b0,1'b0,1'b1,MTR_ALU, 32'h1234,     32'h0,         5'd3, 1'b0,1'b0,1'b1,32'h0,        0,  32'h0,         0,  0,
            {MTR_ALU,1'b1,32'h0,32'h1234,5'd3,1'b0,1'b0});
      issue(1'b1,1'b0,1'b1,MTR_MEM, 32'h30,       32'h0,         5'd9, 1'b1,1'b1,1'b0,32'h88,       1,  32'hCAFEF00D,  1,  2,
            {MTR_MEM,1'b1,32'hCAFEF00D,32'h30,5'd9,1'b0,1'b0});
      issue(1'b1,1'b0,1'b1,MTR_MEM, 32'h40,       32'h0,         5'd10,1'b0,1'b0,1'b0,32'h0,       -1,  32'h0,        15, 16,
            {MTR_MEM,1'b0,32'h0,32'h40,5'd10,1'b1,1'b0});
      issue(1'b1,1'b0,1'b1,MTR_MEM, 32'h13,       32'h0,         5'd11,1'b0,1'b0,1'b0,32'h0,        0,  32'h77777777,  0,  0,
            {MTR_MEM,1'b0,32'h0,32'h13,5'd11,1'b1,1'b1});
      issue(1'b0,1'b0,1'b1,2'b10,   32'h55,       32'h0,         5'd31,1'b0,1'b0,1'b0,32'h0,        0,  32'h0,         0,  0,
            {2'b10,1'b1,32'h0,32'h55,5'd31,1'b1,1'b1});

      // reset during the second wait cycle of a load abandons it
      MemRead_i = 1'b1; RegWrite_i = 1'b1; MemtoReg_i = MTR_MEM;
      alu_result_i = 32'h50; WriteRegister_i = 5'd12;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wait_state", 32'(state_o), 32'(WAIT));
      chk("rst_wait_stall", 32'(stall_o), 32'd1);
      reset = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_req", 32'(dmem_bus.dmem_req), 32'd0);
      chk("abort_state", 32'(state_o), 32'(IDLE));
      chk("abort_regwrite", 32'(RegWrite_o), 32'd0);
      chk("abort_rdata", mem_rdata_o, 32'd0);
      chk("abort_alu", alu_result_o, 32'd0);
      chk("abort_wreg", 32'(WriteRegister_o), 32'd0);
      chk("abort_stall", 32'(stall_o), 32'd0);
      chk("abort_errs", 32'({bus_err_o, align_err_o}), 32'd0);

      repeat (3) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
